dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every data-memory access of the RV32I pipeline. Sits between the MEM stage (MemRead/MemWrite/funct3
//  from the decoded instruction) and the data-memory bus: issues a valid/ready request, waits for the response,
//  stalls the pipeline meanwhile, formats byte/half/word stores and sign/zero-extends loads, and flags misaligned
//  accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYC  256  cycles in REQ+WAIT_RSP before access aborted with bus_err (min 2)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  MemRead      in   1   MEM-stage load
//  MemWrite     in   1   MEM-stage store
//  funct3       in   3   000 B,001 H,010 W,100 BU,101 HU (loads); 000/001/010 (stores)
//  addr         in   32  effective address (ALU result)
//  wdata        in   32  store data (rs2), right-aligned
//  req_valid    out  1   bus request valid
//  req_ready    in   1   bus accepts request
//  req_write    out  1   1=store, 0=load
//  req_addr     out  32  {addr[31:2],2'b00}
//  req_wstrb    out  4   byte enables (0000 on loads)
//  req_wdata    out  32  lane-shifted store data
//  rsp_valid    in   1   read data / write ack returned
//  rsp_rdata    in   32  raw read word
//  stall        out  1   hold PC and IF/ID/EX/MEM registers
//  load_data    out  32  extended load result, valid with done
//  done         out  1   one-cycle pulse: access complete, pipeline may advance
//  misalign     out  1   one-cycle pulse: misaligned access, no bus request made
//  bus_err      out  1   one-cycle pulse coincident with done on timeout
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, captured regs 0; req_valid, req_write, req_wstrb, req_wdata, req_addr, load_data,
//    done, misalign, bus_err all 0. stall = 0.
//  - States IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE.
//  - IDLE: if MemRead|MemWrite: aligned -> capture addr/wdata/funct3/op, go REQ; stall=1 combinationally this cycle.
//    MemRead and MemWrite both 1: treated as load. Misaligned (W with addr[1:0]!=0; H/HU with addr[0]=1): stay IDLE,
//    misalign=1 next cycle for one cycle, stall=0, no request. rsp_valid ignored in IDLE.
//  - REQ: req_valid=1, req_* stable from captured regs until req_valid&req_ready; then WAIT_RSP. stall=1.
//  - WAIT_RSP: stall=1; on rsp_valid capture extended data (loads) -> DONE. rsp_valid in same cycle as req_ready
//    (REQ state) ignored; response must come at least 1 cycle after acceptance.
//  - DONE: done=1, stall=0, load_data valid (0 for stores); MEM inputs ignored this cycle (still same instr); -> IDLE.
//    Minimum access latency: 3 cycles after MemRead seen in IDLE to done (ready and rsp each 1 cycle).
//  - Timeout: counter clears entering REQ, increments each cycle in REQ/WAIT_RSP; at TIMEOUT_CYC-1 go DONE with
//    bus_err=1, load_data=0, req_valid dropped (request abandoned; late rsp_valid ignored).
//  - Stores: SB wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH wstrb=4'b0011<<addr[1:0],
//    wdata={2{wdata[15:0]}}; SW wstrb=4'hF, wdata as is.
//  - Loads: byte = rsp_rdata[8*addr[1:0]+:8], half = rsp_rdata[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend,
//    W raw. Undefined funct3 (011,110,111) treated as W.
//  - rst asserted mid-access: immediate return to IDLE, outputs to reset values; in-flight response dropped.
// TESTING
//  - LW addr=0x100, ready 1st cycle, rsp 0xDEADBEEF 2 cycles later -> req_addr=0x100, wstrb=0, stall held, done pulse
//    with load_data=0xDEADBEEF, stall low same cycle.
//  - SB addr=0x203 wdata=0x000000A5 -> req_wstrb=4'b1000, req_wdata=0xA5A5A5A5, req_addr=0x200, done after write ack.
//  - LB addr=0x2 rsp 0x0080FF00 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x2 -> 0x00000080.
//  - LW addr=0x102 -> misalign pulse, req_valid never asserts, stall=0; SH addr=0x101 likewise.
//  - req_ready held low TIMEOUT_CYC cycles -> bus_err+done same cycle, load_data=0, req_valid low next cycle.
//  - rst pulsed while in WAIT_RSP, then rsp_valid arrives -> all outputs 0, stays IDLE, no done.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the RV32I MEM stage: valid/ready bus request,
// response wait with timeout, store lane formatting and load extension.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_lo;
  logic             access, is_byte, is_half, mis_addr, timeout, enter_done;

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << lo;
      2'b01:   store_strb = 4'b0011 << lo;
      default: store_strb = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs, hs;
    b  = raw[8*lo +: 8];
    h  = raw[16*lo[1] +: 16];
    bs = b;
    hs = h;
    case (f3[1:0])
      2'b00:   extend_load = f3[2] ? {24'h0, b} : bs;
      2'b01:   extend_load = f3[2] ? {16'h0, h} : hs;
      default: extend_load = raw;
    endcase
  endfunction

  assign access   = MemRead | MemWrite;
  assign is_byte  = (funct3[1:0] == 2'b00);
  assign is_half  = (funct3[1:0] == 2'b01);
  assign mis_addr = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
  assign timeout  = ((state == REQ) || (state == WAIT_RSP)) &&
                    (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (access && !mis_addr) begin
          stall   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (timeout)        state_n = DONE;
        else if (req_ready) state_n = WAIT_RSP;
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (timeout || rsp_valid) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_valid  = (state == REQ);
  assign done       = (state == DONE);
  assign enter_done = (state_n == DONE) && (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_f3    <= '0;
      cap_lo    <= '0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wstrb <= '0;
      req_wdata <= '0;
      load_data <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state    <= state_n;
      misalign <= (state == IDLE) && access && mis_addr;
      bus_err  <= enter_done && timeout;

      if (state == IDLE && state_n == REQ) begin
        cnt       <= '0;
        cap_f3    <= funct3;
        cap_lo    <= addr[1:0];
        // simultaneous MemRead and MemWrite resolves to a load
        req_write <= !MemRead;
        req_addr  <= {addr[31:2], 2'b00};
        req_wstrb <= MemRead ? 4'h0 : store_strb(funct3, addr[1:0]);
        req_wdata <= MemRead ? 32'h0 : store_data(funct3, wdata);
      end else if (state == REQ || state == WAIT_RSP) begin
        cnt <= cnt + 1'b1;
      end

      if (enter_done) begin
        load_data <= (timeout || req_write) ? 32'h0 : extend_load(cap_f3, cap_lo, rsp_rdata);
      end
    end
  end

endmodule
